// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the core (master) and the UART transmitter FIFO (slave).
// A byte transfers on a rising clock edge when valid_i and ready_o are both high.
interface uart_tx_fifo_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter, LSB first and idle high, fed by a circular byte FIFO (8N1 frames by default).
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit, giving 8E1 frames.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to hold a byte
// S_START  | driving the start bit (0)
// S_DATA   | driving data bits 0..7, LSB first
// S_PARITY | driving the even-parity bit (parity build only)
// S_STOP   | driving the stop bit (1)
module uart_tx_fifo #(
    parameter int FREQ       = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    uart_tx_fifo_if.slave                 bus,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CLK_PER_BIT = FREQ / BAUD;
    localparam int TW          = $clog2(CLK_PER_BIT);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = AW + 1;

    localparam logic [TW-1:0] TMAX = TW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state, state_next;
    logic          tx, tx_next;
    logic [TW-1:0] timer, timer_next;
    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_idx, bit_next;
    logic          busy, busy_next;
    logic          expired;
    logic          pop;
    logic          push;
    logic          ready;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [7:0]    head;

`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    assign ready        = (count != FULL);
    assign push         = bus.valid_i & ready;
    assign head         = mem[rd_ptr];
    assign expired      = (timer == '0);

    assign bus.ready_o  = ready;
    assign uart_tx_o    = tx;
    assign busy_o       = busy;
    assign fifo_count_o = count;

    // The FSM only looks at the registered count, so a byte pushed into an
    // empty FIFO is first seen one edge later.
    always_comb begin
        state_next = state;
        tx_next    = tx;
        shift_next = shift;
        bit_next   = bit_idx;
        timer_next = expired ? timer : timer - 1'b1;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = head;
                    tx_next    = 1'b0;
                    timer_next = TMAX;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (expired) begin
                    tx_next    = shift[0];
                    bit_next   = 3'd0;
                    timer_next = TMAX;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (expired) begin
                    timer_next = TMAX;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity;
                        state_next = S_PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = S_STOP;
`endif
                    end else begin
                        tx_next    = shift[1];
                        shift_next = {1'b0, shift[7:1]};
                        bit_next   = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (expired) begin
                    tx_next    = 1'b1;
                    timer_next = TMAX;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (expired) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = head;
                        tx_next    = 1'b0;
                        timer_next = TMAX;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
        busy_next = (state_next != S_IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            shift   <= '0;
            bit_idx <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            timer   <= timer_next;
            shift   <= shift_next;
            bit_idx <= bit_next;
            count   <= count_next;
            busy    <= busy_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_i;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the whole byte, latched when it leaves the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity <= 1'b0;
        end else if (pop) begin
            parity <= ^head;
        end
    end
`endif

endmodule
